// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS shim layer: segment tuser payload and RX arbiter state.
package ofs_fim_pcie_ss_shims_pkg;

  localparam int unsigned HDR_W = 128;
  localparam int unsigned BAR_W = 8;

  // Per-segment sideband: header is valid only on the SOP beat.
  typedef struct packed {
    logic             hvalid;
    logic [HDR_W-1:0] hdr;
    logic [BAR_W-1:0] bar;
  } t_tuser_seg;

  localparam int unsigned TUSER_SEG_W = $bits(t_tuser_seg);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_rx_arb_state;

  // Index width for an n-entry select, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofs_fim_rr_pick.sv
// Combinational round-robin pick: rotate requests by ptr, priority-encode, unrotate.
module ofs_fim_rr_pick
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic          hit;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned b);
    return IW'((32'(a) + b) % N);
  endfunction

  // Rotate so that the request at ptr lands in bit 0.
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = req[wrap_add(ptr, i)];
    end
  end

  // Lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !hit) begin
        off = IW'(i);
        hit = 1'b1;
      end
    end
  end

  assign any_req   = hit;
  assign grant_idx = wrap_add(ptr, 32'(off));

endmodule

// File: rtl/ofs_fim_pcie_ss_rx_pkt_arb.sv
// Packet-atomic round-robin merge of NUM_IN aligned TLP streams onto one registered AXI-S.
module ofs_fim_pcie_ss_rx_pkt_arb
  import ofs_fim_pcie_ss_shims_pkg::*;
#(
  parameter  int unsigned NUM_IN = 2,
  parameter  int unsigned DATA_W = 512,
  parameter  int unsigned USER_W = TUSER_SEG_W,
  parameter  int unsigned CNT_W  = 32,
  localparam int unsigned KEEP_W = DATA_W / 8,
  localparam int unsigned SRC_W  = idx_w(NUM_IN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          in_tvalid,
  output logic [NUM_IN-1:0]          in_tready,
  input  logic [NUM_IN*DATA_W-1:0]   in_tdata,
  input  logic [NUM_IN*KEEP_W-1:0]   in_tkeep,
  input  logic [NUM_IN-1:0]          in_tlast,
  input  logic [NUM_IN*USER_W-1:0]   in_tuser,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [DATA_W-1:0]          out_tdata,
  output logic [KEEP_W-1:0]          out_tkeep,
  output logic                       out_tlast,
  output logic [USER_W-1:0]          out_tuser,
  output logic [SRC_W-1:0]           out_src,
  output logic [NUM_IN*CNT_W-1:0]    pkt_cnt
);

  t_rx_arb_state    state_q, state_d;
  logic [SRC_W-1:0] lock_q, lock_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load;
  logic             accept;
  logic             acc_last;
  logic [CNT_W-1:0] cnt_q [NUM_IN];

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] g);
    return SRC_W'((32'(g) + 32'd1) % NUM_IN);
  endfunction

  ofs_fim_rr_pick #(.N(NUM_IN)) u_pick (
    .req       (in_tvalid),
    .ptr       (rr_ptr_q),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  assign load     = !out_tvalid || out_tready;
  assign accept   = |(in_tvalid & in_tready);
  assign acc_last = in_tlast[grant_idx];

  // State register: FSM state, packet lock owner and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      lock_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: lock on a non-last beat, release and advance the pointer on tlast.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (acc_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = next_idx(grant_idx);
      end else begin
        state_d  = ARB_LOCKED;
        lock_d   = grant_idx;
      end
    end
  end

  // Grant decode: locked owner wins outright, otherwise the round-robin pick.
  always_comb begin
    grant_idx = (state_q == ARB_LOCKED) ? lock_q : pick_idx;
    grant_vld = (state_q == ARB_LOCKED) || pick_any;
    in_tready = '0;
    for (int unsigned g = 0; g < NUM_IN; g++) begin
      in_tready[g] = rst_n && load && grant_vld && (grant_idx == SRC_W'(g));
    end
  end

  // Output valid/source: set on accept, drop once consumed with nothing new behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
      out_src    <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_src    <= grant_idx;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  // Output payload: captured from the granted input; tuser/tkeep pass through untouched.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_tdata <= in_tdata[32'(grant_idx)*DATA_W +: DATA_W];
      out_tkeep <= in_tkeep[32'(grant_idx)*KEEP_W +: KEEP_W];
      out_tuser <= in_tuser[32'(grant_idx)*USER_W +: USER_W];
      out_tlast <= acc_last;
    end
  end

  // Per-input packet counters, bumped on each accepted tlast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < NUM_IN; g++) cnt_q[g] <= '0;
    end else if (accept && acc_last) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  a_tready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_tready));

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_pkt_arb.sv
// Randomized bench for the RX packet arbiter against a transaction-level reference model.
module tb_ofs_fim_pcie_ss_rx_pkt_arb;
  import ofs_fim_pcie_ss_shims_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = TUSER_SEG_W;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_tvalid, in_tready, in_tlast;
  logic [N*DW-1:0] in_tdata;
  logic [N*KW-1:0] in_tkeep;
  logic [N*UW-1:0] in_tuser;
  logic            out_tvalid, out_tready, out_tlast;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic [UW-1:0]   out_tuser;
  logic [SW-1:0]   out_src;
  logic [N*CW-1:0] pkt_cnt;

  ofs_fim_pcie_ss_rx_pkt_arb #(.NUM_IN(N), .DATA_W(DW), .USER_W(UW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tlast(in_tlast), .in_tuser(in_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser(out_tuser),
    .out_src(out_src), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus knobs
  int          p_valid [N];
  int          fix_len [N];
  int          max_len  = 4;
  int          p_ready  = 16;
  logic [N-1:0] en_mask = '0;
  bit          no_new   = 1'b0;

  // Source state: beats still owed in the current packet
  int          rem [N];
  logic [N-1:0] acc = '0;

  // Reference model
  bit          m_ovalid;
  int          m_osrc;
  bit          m_locked;
  int          m_lock;
  int          m_ptr;
  logic [CW-1:0] m_cnt [N];
  beat_t       q [N][$];
  bit          m_out_mid;
  int          m_out_pkt_src;
  int          tot_out;
  int          obs_src [$];

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ovalid = 1'b0; m_osrc = 0; m_locked = 1'b0; m_lock = 0; m_ptr = 0;
    m_out_mid = 1'b0; m_out_pkt_src = 0; tot_out = 0;
    for (int i = 0; i < int'(N); i++) begin
      m_cnt[i] = '0;
      q[i].delete();
    end
  endtask

  // Present a new beat on every input that is idle or just had its beat taken.
  task automatic drive();
    out_tready = ($urandom % 16) < 32'(p_ready);
    for (int i = 0; i < int'(N); i++) begin
      if (!rst_n) begin
        in_tvalid[i] = 1'b0;
        rem[i] = 0;
      end else if (!in_tvalid[i] || acc[i]) begin
        if (en_mask[i] && (($urandom % 16) < 32'(p_valid[i])) && !(no_new && rem[i] == 0)) begin
          if (rem[i] == 0) rem[i] = (fix_len[i] > 0) ? fix_len[i] : int'($urandom_range(1, max_len));
          for (int w = 0; w < int'(DW / 32); w++) in_tdata[i*DW + w*32 +: 32] = $urandom;
          for (int w = 0; w < int'(KW / 32); w++) in_tkeep[i*KW + w*32 +: 32] = $urandom;
          for (int b = 0; b < int'(UW); b++) in_tuser[i*UW + b] = 1'($urandom);
          in_tlast[i]  = (rem[i] == 1);
          in_tvalid[i] = 1'b1;
        end else begin
          in_tvalid[i] = 1'b0;
        end
      end
    end
  endtask

  // Compare DUT against the model for this cycle, then advance the model over the clock edge.
  task automatic model_step();
    logic [N-1:0] exp_rdy;
    bit  load;
    int  g;
    beat_t h, b;
    acc = in_tvalid & in_tready;
    if (!rst_n) begin
      check_eq("rst_in_tready", DW'(in_tready), DW'(0));
      acc = '0;
      model_reset();
      return;
    end
    check_eq("out_tvalid", DW'(out_tvalid), DW'(m_ovalid));
    if (m_ovalid) begin
      check_eq("out_src", DW'(out_src), DW'(m_osrc));
      if (q[m_osrc].size() == 0) begin
        check_eq("ref_q_empty", DW'(q[m_osrc].size()), DW'(1));
      end else begin
        h = q[m_osrc][0];
        check_eq("out_tdata", out_tdata, h.d);
        check_eq("out_tkeep", DW'(out_tkeep), DW'(h.k));
        check_eq("out_tlast", DW'(out_tlast), DW'(h.l));
        check_eq("out_tuser", DW'(out_tuser), DW'(h.u));
        if (out_tready) begin
          void'(q[m_osrc].pop_front());
          obs_src.push_back(m_osrc);
          if (m_out_mid) check_eq("interleave", DW'(m_osrc), DW'(m_out_pkt_src));
          m_out_mid = !h.l;
          m_out_pkt_src = m_osrc;
          if (h.l) tot_out++;
        end
      end
    end
    for (int i = 0; i < int'(N); i++)
      check_eq($sformatf("pkt_cnt%0d", i), DW'(pkt_cnt[i*CW +: CW]), DW'(m_cnt[i]));

    load = !m_ovalid || out_tready;
    g = -1;
    if (load) begin
      if (m_locked) g = m_lock;
      else
        for (int k = 0; k < int'(N); k++)
          if (g < 0 && in_tvalid[(m_ptr + k) % int'(N)]) g = (m_ptr + k) % int'(N);
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check_eq("in_tready", DW'(in_tready), DW'(exp_rdy));

    if (g >= 0 && in_tvalid[g]) begin
      b.d = in_tdata[g*DW +: DW];
      b.k = in_tkeep[g*KW +: KW];
      b.l = in_tlast[g];
      b.u = in_tuser[g*UW +: UW];
      q[g].push_back(b);
      m_ovalid = 1'b1;
      m_osrc = g;
      if (b.l) begin
        m_cnt[g] = m_cnt[g] + 1;
        m_locked = 1'b0;
        m_ptr = (g + 1) % int'(N);
      end else begin
        m_locked = 1'b1;
        m_lock = g;
      end
    end else if (out_tready) begin
      m_ovalid = 1'b0;
    end
    for (int i = 0; i < int'(N); i++) if (acc[i]) rem[i]--;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_step();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) step();
    rst_n = 1'b1;
    obs_src.delete();
  endtask

  task automatic set_all(input int pv, input int fl);
    for (int i = 0; i < int'(N); i++) begin
      p_valid[i] = pv;
      fix_len[i] = fl;
    end
  endtask

  initial begin
    int cyc;
    int sum;
    rst_n = 1'b0;
    in_tvalid = '0; in_tlast = '0; in_tdata = '0; in_tkeep = '0; in_tuser = '0;
    out_tready = 1'b0;
    for (int i = 0; i < int'(N); i++) rem[i] = 0;
    set_all(16, 1);
    model_reset();

    // 1: all inputs streaming single-beat packets, no backpressure -> strict rotation
    en_mask = '1; p_ready = 16;
    do_reset(2);
    step();
    check_eq("rst_out_tvalid", DW'(out_tvalid), DW'(0));
    check_eq("rst_out_src", DW'(out_src), DW'(0));
    check_eq("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));
    check_eq("rst_first_grant", DW'(in_tready), DW'(4'b0001));
    repeat (12) step();
    check_eq("t1_beats", DW'(obs_src.size() >= 8), DW'(1));
    for (int k = 0; k < 8 && k < obs_src.size(); k++)
      check_eq($sformatf("t1_src%0d", k), DW'(obs_src[k]), DW'(k % int'(N)));

    // 2: in0 3-beat packets vs in1 single-beat packets -> 0,0,0,1 repeating
    en_mask = 4'b0011; fix_len[0] = 3; fix_len[1] = 1;
    do_reset(1);
    repeat (12) step();
    check_eq("t2_beats", DW'(obs_src.size() >= 8), DW'(1));
    for (int k = 0; k < 8 && k < obs_src.size(); k++)
      check_eq($sformatf("t2_src%0d", k), DW'(obs_src[k]), DW'((k % 4 == 3) ? 1 : 0));

    // 3: in0 with valid gaps mid-packet, in1 always valid
    fix_len[0] = 5; p_valid[0] = 6;
    repeat (60) step();

    // 4: output backpressure for 5 cycles with a beat held
    set_all(16, 0); en_mask = '1;
    repeat (4) step();
    p_ready = 0;
    repeat (5) begin
      step();
      check_eq("t4_hold_tvalid", DW'(out_tvalid), DW'(1));
      check_eq("t4_hold_tready", DW'(in_tready), DW'(0));
    end
    p_ready = 16;
    repeat (4) step();

    // 5: reset mid-packet on in2 -> output empties, pointer back to 0
    set_all(16, 0); en_mask = 4'b0100; fix_len[2] = 8;
    do_reset(1);
    repeat (4) step();
    check_eq("t5_in2_locked", DW'(out_src), DW'(2));
    en_mask = '1;
    do_reset(1);
    step();
    check_eq("t5_out_tvalid", DW'(out_tvalid), DW'(0));
    check_eq("t5_first_grant", DW'(in_tready), DW'(4'b0001));

    // 6: random traffic on all inputs with 15/16 output ready
    for (int i = 0; i < int'(N); i++) begin
      p_valid[i] = int'($urandom_range(4, 16));
      fix_len[i] = 0;
    end
    max_len = 5; p_ready = 15; en_mask = '1;
    do_reset(1);
    cyc = 0;
    while (tot_out < 3000 && cyc < 60000) begin
      step();
      cyc++;
    end
    check_eq("t6_budget", DW'(tot_out >= 3000), DW'(1));
    no_new = 1'b1; p_ready = 16; set_all(16, 0);
    repeat (40) step();
    for (int i = 0; i < int'(N); i++)
      check_eq($sformatf("t6_drain_q%0d", i), DW'(q[i].size()), DW'(0));
    sum = 0;
    for (int i = 0; i < int'(N); i++) sum += int'(pkt_cnt[i*CW +: CW]);
    check_eq("t6_cnt_sum", DW'(sum), DW'(tot_out));
    check_eq("t6_idle", DW'(out_tvalid), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
